sba_xbar: RTL and testbench

Parametrised SBA interconnect that generalises the single-CPU address decoder in the SoC top level to NM masters and NS slaves. It arbitrates masters round-robin and routes each transaction to one slave through a per-slave top-byte address match. Unmapped accesses and accesses to hung slaves complete with an error acknowledge. It sits between the CPU and any future DMA master on one side and BRAM/CLINT/PLIC/UART/SPI/SRAM on the other.

---
 rtl/sba_xbar.sv | 150 +++++++++++++++
 tb/tb_sba_xbar.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sba_xbar.sv
// sba_xbar: NM-master / NS-slave SBA interconnect. Masters are arbitrated
// round-robin, the winner's address is decoded on its top byte to pick a
// slave, and unmapped or hung accesses complete with an error acknowledge.
module sba_xbar #(
    parameter int              NM         = 2,
    parameter int              NS         = 6,
    parameter logic [NS*8-1:0] SLAVE_BASE = 48'h80_20_10_0C_02_00,
    parameter int              TIMEOUT    = 255,
    parameter logic [31:0]     ERR_DATA   = 32'hDEADBEEF
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [NM-1:0]        i_m_stb,
    input  logic [NM-1:0][3:0]   i_m_we,
    input  logic [NM-1:0][31:0]  i_m_addr,
    input  logic [NM-1:0][31:0]  i_m_dat_w,
    output logic [NM-1:0]        o_m_ack,
    output logic [NM-1:0][31:0]  o_m_dat_r,
    output logic [NS-1:0]        o_s_stb,
    output logic [31:0]          o_s_addr,
    output logic [3:0]           o_s_we,
    output logic [31:0]          o_s_dat_w,
    input  logic [NS-1:0]        i_s_ack,
    input  logic [NS-1:0][31:0]  i_s_dat_r,
    output logic                 o_err,
    output logic [31:0]          o_err_addr,
    output logic [2:0]           o_err_master
);

    localparam int GW = (NM > 1) ? $clog2(NM) : 1;
    localparam int SW = (NS > 1) ? $clog2(NS) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, BUSY, ERR} state_t;

    state_t        state;
    logic [GW-1:0] grant;
    logic [GW-1:0] rr_ptr;
    logic [SW-1:0] sel;
    logic [TW-1:0] cnt;

    logic          req_hit;
    logic [GW-1:0] req_idx;
    logic [GW-1:0] scan;
    logic          dec_hit;
    logic [SW-1:0] dec_idx;
    logic          s_ack;

    // Round-robin pick: scan from rr_ptr+1 so the previous winner ranks last
    always_comb begin
        req_hit = 1'b0;
        req_idx = '0;
        scan    = '0;
        for (int i = NM; i >= 1; i--) begin
            scan = GW'((int'(rr_ptr) + i) % NM);
            if (i_m_stb[scan]) begin
                req_hit = 1'b1;
                req_idx = scan;
            end
        end
    end

    // Top-byte decode of the candidate address; lowest matching slave wins
    always_comb begin
        dec_hit = 1'b0;
        dec_idx = '0;
        for (int s = NS - 1; s >= 0; s--) begin
            if (i_m_addr[req_idx][31:24] == SLAVE_BASE[s*8 +: 8]) begin
                dec_hit = 1'b1;
                dec_idx = SW'(s);
            end
        end
    end

    // Slave-side mux and master acks; the slave ack is passed straight through
    always_comb begin
        s_ack     = i_m_stb[grant] && i_s_ack[sel];
        o_s_addr  = i_m_addr[grant];
        o_s_we    = i_m_we[grant];
        o_s_dat_w = i_m_dat_w[grant];
        o_s_stb   = '0;
        o_m_ack   = '0;
        o_m_dat_r = '0;
        o_err     = 1'b0;
        case (state)
            BUSY: begin
                o_s_stb[sel] = i_m_stb[grant];
                if (s_ack) begin
                    o_m_ack[grant]   = 1'b1;
                    o_m_dat_r[grant] = i_s_dat_r[sel];
                end
            end
            ERR: begin
                o_m_ack[grant]   = 1'b1;
                o_m_dat_r[grant] = ERR_DATA;
                o_err            = 1'b1;
            end
            default: ;
        endcase
    end

    // Transaction FSM: grant/decode in IDLE, wait or time out in BUSY,
    // one-cycle error completion in ERR
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= IDLE;
            grant        <= '0;
            rr_ptr       <= GW'(NM - 1);
            sel          <= '0;
            cnt          <= '0;
            o_err_addr   <= '0;
            o_err_master <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_hit) begin
                        grant  <= req_idx;
                        rr_ptr <= req_idx;
                        cnt    <= '0;
                        if (dec_hit) begin
                            sel   <= dec_idx;
                            state <= BUSY;
                        end else begin
                            state        <= ERR;
                            o_err_addr   <= i_m_addr[req_idx];
                            o_err_master <= 3'(req_idx);
                        end
                    end
                end
                BUSY: begin
                    if (!i_m_stb[grant]) begin
                        // master abandoned the access: drop it silently
                        state <= IDLE;
                    end else if (i_s_ack[sel]) begin
                        state <= IDLE;
                    end else if (cnt == TW'(TIMEOUT - 1)) begin
                        state        <= ERR;
                        o_err_addr   <= i_m_addr[grant];
                        o_err_master <= 3'(grant);
                    end else if (cnt != TW'(TIMEOUT)) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ERR: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sba_xbar.sv
// tb_sba_xbar: randomized self-checking bench for sba_xbar. Slaves are
// modelled as "ack after N cycles of strobe"; expected ack timing, data and
// error reporting come from the latency rules of the interconnect.
module tb_sba_xbar;

    localparam int          NM   = 2;
    localparam int          NS   = 6;
    localparam int          TO   = 8;
    localparam logic [31:0] ERRD = 32'hDEADBEEF;

    logic                clk = 1'b0;
    logic                rst;
    logic [NM-1:0]       m_stb;
    logic [NM-1:0][3:0]  m_we;
    logic [NM-1:0][31:0] m_addr;
    logic [NM-1:0][31:0] m_dat_w;
    logic [NM-1:0]       m_ack;
    logic [NM-1:0][31:0] m_dat_r;
    logic [NS-1:0]       s_stb;
    logic [31:0]         s_addr;
    logic [3:0]          s_we;
    logic [31:0]         s_dat_w;
    logic [NS-1:0]       s_ack;
    logic [NS-1:0][31:0] s_dat_r;
    logic                err;
    logic [31:0]         err_addr;
    logic [2:0]          err_master;

    int checks = 0;
    int errors = 0;

    int            slat[NS];
    int            scnt[NS] = '{default: 0};
    logic [NS-1:0] extra_ack;
    logic [7:0]    bases[NS] = '{8'h00, 8'h02, 8'h0C, 8'h10, 8'h20, 8'h80};

    int          last_grant;
    logic [31:0] last_eaddr;
    int          last_em;

    always #5 clk = ~clk;

    sba_xbar #(.NM(NM), .NS(NS), .TIMEOUT(TO)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_m_stb(m_stb), .i_m_we(m_we), .i_m_addr(m_addr), .i_m_dat_w(m_dat_w),
        .o_m_ack(m_ack), .o_m_dat_r(m_dat_r),
        .o_s_stb(s_stb), .o_s_addr(s_addr), .o_s_we(s_we), .o_s_dat_w(s_dat_w),
        .i_s_ack(s_ack), .i_s_dat_r(s_dat_r),
        .o_err(err), .o_err_addr(err_addr), .o_err_master(err_master)
    );

    // slave model: count consecutive strobe cycles
    always @(posedge clk)
        for (int s = 0; s < NS; s++) scnt[s] <= s_stb[s] ? scnt[s] + 1 : 0;

    // slave model: ack once strobe has been seen for slat cycles (0 = same cycle)
    always_comb begin
        s_ack = extra_ack;
        for (int s = 0; s < NS; s++)
            if (s_stb[s] && scnt[s] >= slat[s]) s_ack[s] = 1'b1;
    end

    // one isolated transaction from master m, checked cycle by cycle
    task automatic run_txn(input int m, input logic [31:0] addr, input logic [3:0] we,
                           input logic [31:0] wd, input int lat, input logic [31:0] rd,
                           input string tag);
        int s, ack_cyc;
        logic tmo, exp_e;
        logic [31:0] exp_d;
        logic [NS-1:0] exp_stb;
        logic [NM-1:0] exp_ack;
        logic [NM-1:0][31:0] exp_dv;
        s = -1;
        for (int i = NS - 1; i >= 0; i--) if (addr[31:24] == bases[i]) s = i;
        for (int i = 0; i < NS; i++) begin
            slat[i]    = lat;
            s_dat_r[i] = (i == s) ? rd : $urandom;
        end
        tmo = 1'b0;
        if (s < 0) begin
            ack_cyc = 2; exp_d = ERRD; exp_e = 1'b1;
        end else if (lat >= TO) begin
            ack_cyc = TO + 2; exp_d = ERRD; exp_e = 1'b1; tmo = 1'b1;
        end else begin
            ack_cyc = lat + 2; exp_d = rd; exp_e = 1'b0;
        end
        @(posedge clk); #1;
        m_stb[m] = 1'b1; m_addr[m] = addr; m_we[m] = we; m_dat_w[m] = wd;
        for (int c = 1; c <= ack_cyc; c++) begin
            @(negedge clk);
            exp_stb = '0;
            if (s >= 0 && c >= 2 && (c < ack_cyc || !tmo)) exp_stb[s] = 1'b1;
            checks++;
            if (s_stb !== exp_stb) begin
                errors++;
                $display("FAIL %s s_stb cyc %0d got %b want %b", tag, c, s_stb, exp_stb);
            end
            if (exp_stb != '0) begin
                checks++;
                if (s_addr !== addr || s_we !== we || s_dat_w !== wd) begin
                    errors++;
                    $display("FAIL %s s_bus cyc %0d got %h/%h/%h want %h/%h/%h",
                             tag, c, s_addr, s_we, s_dat_w, addr, we, wd);
                end
            end
            if (c < ack_cyc) begin
                checks++;
                if (m_ack !== '0 || m_dat_r !== '0 || err !== 1'b0) begin
                    errors++;
                    $display("FAIL %s early cyc %0d ack %b dat %h err %b want 0", tag, c, m_ack, m_dat_r, err);
                end
            end
        end
        exp_ack = '0; exp_ack[m] = 1'b1;
        exp_dv = '0;  exp_dv[m] = exp_d;
        checks++;
        if (m_ack !== exp_ack || m_dat_r !== exp_dv || err !== exp_e) begin
            errors++;
            $display("FAIL %s ack got %b/%h/%b want %b/%h/%b", tag, m_ack, m_dat_r, err, exp_ack, exp_dv, exp_e);
        end
        if (exp_e) begin last_eaddr = addr; last_em = m; end
        last_grant = m;
        checks++;
        if (err_addr !== last_eaddr || err_master !== 3'(last_em)) begin
            errors++;
            $display("FAIL %s err_info got %h/%0d want %h/%0d", tag, err_addr, err_master, last_eaddr, last_em);
        end
        @(posedge clk); #1;
        m_stb[m] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; m_stb = '0; extra_ack = '0;
        m_addr[0] = 32'h1111_0001; m_addr[1] = 32'h2222_0002;
        m_we[0] = 4'h3; m_we[1] = 4'hC;
        m_dat_w[0] = 32'hAAAA_0000; m_dat_w[1] = 32'hBBBB_0000;
        for (int i = 0; i < NS; i++) begin slat[i] = 0; s_dat_r[i] = $urandom; end
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (m_ack !== '0 || m_dat_r !== '0 || s_stb !== '0 || err !== 1'b0 ||
            err_addr !== '0 || err_master !== '0) begin
            errors++;
            $display("FAIL reset_out ack %b dat %h stb %b err %b ea %h em %0d want all 0",
                     m_ack, m_dat_r, s_stb, err, err_addr, err_master);
        end
        checks++;
        if (s_addr !== 32'h1111_0001 || s_we !== 4'h3 || s_dat_w !== 32'hAAAA_0000) begin
            errors++;
            $display("FAIL reset_mux got %h/%h/%h want master 0 bus", s_addr, s_we, s_dat_w);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        last_grant = NM - 1; last_eaddr = '0; last_em = 0;
    endtask

    task automatic test_single_read();
        run_txn(0, 32'h0000_0010, 4'h0, 32'h0, 1, 32'h1234_5678, "single_read");
        run_txn(1, 32'h0200_0004, 4'h0, 32'h0, 0, 32'hCAFE_0001, "comb_ack");
    endtask

    task automatic test_unmapped();
        run_txn(0, 32'h4000_0000, 4'hF, 32'h5555_AAAA, 0, 32'h0, "unmapped");
    endtask

    task automatic test_timeout();
        run_txn(0, 32'h1000_0040, 4'h0, 32'h0, 255, 32'h0, "timeout");
        // a late ack from the hung slave must not reach anyone
        @(posedge clk); #1;
        extra_ack[3] = 1'b1;
        @(negedge clk);
        checks++;
        if (m_ack !== '0 || err !== 1'b0 || s_stb !== '0 || err_addr !== 32'h1000_0040) begin
            errors++;
            $display("FAIL stale_ack ack %b err %b stb %b ea %h want 0/0/0/10000040", m_ack, err, s_stb, err_addr);
        end
        @(posedge clk); #1;
        extra_ack = '0;
    endtask

    task automatic test_exact_timeout();
        run_txn(1, 32'h2000_0008, 4'h0, 32'h0, TO - 1, 32'h0BAD_F00D, "exact_timeout");
    endtask

    task automatic test_rr();
        logic [NM-1:0] exp_ack;
        logic [NM-1:0][31:0] exp_dv;
        int nxt;
        for (int i = 0; i < NS; i++) begin slat[i] = 0; s_dat_r[i] = $urandom; end
        @(posedge clk); #1;
        m_addr[0] = 32'h8000_0000; m_addr[1] = 32'h8000_0100;
        m_we[0] = 4'h1; m_we[1] = 4'h2;
        m_stb = '1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c % 2 == 1) begin
                checks++;
                if (m_ack !== '0 || s_stb !== '0) begin
                    errors++;
                    $display("FAIL rr_idle cyc %0d ack %b stb %b want 0", c, m_ack, s_stb);
                end
            end else begin
                nxt = (last_grant + 1) % NM;
                exp_ack = '0; exp_ack[nxt] = 1'b1;
                exp_dv = '0;  exp_dv[nxt] = s_dat_r[5];
                checks++;
                if (m_ack !== exp_ack || m_dat_r !== exp_dv || s_stb !== 6'b100000 || s_addr !== m_addr[nxt]) begin
                    errors++;
                    $display("FAIL rr_grant cyc %0d ack %b dat %h stb %b addr %h want %b %h 100000 %h",
                             c, m_ack, m_dat_r, s_stb, s_addr, exp_ack, exp_dv, m_addr[nxt]);
                end
                last_grant = nxt;
            end
        end
        @(posedge clk); #1;
        m_stb = '0;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < NS; i++) slat[i] = 255;
        @(posedge clk); #1;
        m_addr[0] = 32'h0C00_0010; m_addr[1] = 32'h2000_0000; m_stb[0] = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (s_stb !== 6'b000100) begin
            errors++;
            $display("FAIL rstmid_busy stb %b want 000100", s_stb);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; m_stb = '0;
        @(negedge clk);
        checks++;
        if (m_ack !== '0 || m_dat_r !== '0 || s_stb !== '0 || err !== 1'b0 ||
            err_addr !== '0 || err_master !== '0 || s_addr !== m_addr[0]) begin
            errors++;
            $display("FAIL rstmid_out ack %b dat %h stb %b err %b ea %h em %0d sa %h want 0s and master 0 addr",
                     m_ack, m_dat_r, s_stb, err, err_addr, err_master, s_addr);
        end
        last_grant = NM - 1; last_eaddr = '0; last_em = 0;
        // both masters re-issue together; master 0 must win first
        for (int i = 0; i < NS; i++) slat[i] = 0;
        @(posedge clk); #1;
        m_addr[0] = 32'h0000_0100; m_addr[1] = 32'h0000_0200; m_stb = '1;
        repeat (2) @(negedge clk);
        checks++;
        if (m_ack !== 2'b01 || m_dat_r[0] !== s_dat_r[0] || err !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_reissue ack %b dat %h err %b want 01 %h 0", m_ack, m_dat_r[0], err, s_dat_r[0]);
        end
        last_grant = 0;
        @(posedge clk); #1;
        m_stb = '0;
    endtask

    task automatic test_random();
        int lats[7] = '{0, 1, 2, 3, TO - 1, TO, 255};
        int m, s, lat;
        logic [7:0] top;
        logic [31:0] addr;
        logic hit;
        for (int n = 0; n < 16; n++) begin
            m = $urandom_range(0, NM - 1);
            lat = lats[$urandom_range(0, 6)];
            if ($urandom_range(0, 3) != 0) begin
                s = $urandom_range(0, NS - 1);
                top = bases[s];
            end else begin
                do begin
                    top = 8'($urandom);
                    hit = 1'b0;
                    for (int i = 0; i < NS; i++) if (top == bases[i]) hit = 1'b1;
                end while (hit);
            end
            addr = {top, 24'($urandom)};
            run_txn(m, addr, 4'($urandom), $urandom, lat, $urandom, "random");
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_unmapped();
        test_timeout();
        test_exact_timeout();
        test_rr();
        test_reset_mid();
        test_random();
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
